bcd_stopwatch: RTL

- Upstream digit source for the 4-digit seven-segment display multiplexer.
- Debounces raw push-buttons, runs a start/pause/clear state machine, and keeps a 4-digit BCD time in SS.hh format (00.00 to 59.99).
- Presents the time as four packed BCD nibbles that the display mux selects per anode.

---
 rtl/bcd_stopwatch.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/bcd_stopwatch.sv
// Stopwatch digit source: debounced start/clear buttons drive an IDLE/RUN/PAUSED FSM that counts SS.hh in BCD.
// Optional lap-hold display freeze is built when BCD_STOPWATCH_LAP_EN is defined.

module bcd_stopwatch_btn #(
  parameter int DEB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);
  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic          sync1_q, sync2_q, deb_q, deb_d1_q;
  logic [CW-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      deb_q    <= 1'b0;
      deb_d1_q <= 1'b0;
      cnt_q    <= '0;
      press    <= 1'b0;
    end else begin
      sync1_q  <= btn;
      sync2_q  <= sync1_q;
      deb_d1_q <= deb_q;
      press    <= deb_q & ~deb_d1_q;
      // Any cycle agreeing with the accepted level restarts the stability count.
      if (sync2_q != deb_q) begin
        if (cnt_q == CW'(DEB_CYCLES - 1)) begin
          deb_q <= sync2_q;
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end
endmodule

module bcd_stopwatch #(
  parameter int TICK_DIV   = 1000000,
  parameter int DEB_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_start,
  input  logic        btn_clear,
  input  logic        btn_lap,
  output logic [15:0] digits,
  output logic        running,
  output logic        wrap
);
  localparam int PW = $clog2(TICK_DIV);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED} state_t;

  state_t          state_q, state_d;
  logic   [PW-1:0] presc_q;
  logic   [15:0]   time_q, time_inc;
  logic            at_max, tick, start_p, clear_p;

  bcd_stopwatch_btn #(.DEB_CYCLES(DEB_CYCLES)) u_btn_start (
    .clk(clk), .rst_n(rst_n), .btn(btn_start), .press(start_p)
  );
  bcd_stopwatch_btn #(.DEB_CYCLES(DEB_CYCLES)) u_btn_clear (
    .clk(clk), .rst_n(rst_n), .btn(btn_clear), .press(clear_p)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    if (clear_p) begin
      state_d = IDLE;
    end else if (start_p) begin
      case (state_q)
        IDLE:    state_d = RUN;
        RUN:     state_d = PAUSED;
        PAUSED:  state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  assign tick    = (state_q == RUN) && (presc_q == PW'(TICK_DIV - 1));
  assign running = (state_q == RUN);

  // Ripple BCD increment; at_max flags the 59.99 -> 00.00 rollover.
  always_comb begin
    time_inc = time_q;
    at_max   = 1'b0;
    if (time_q[3:0] != 4'd9) begin
      time_inc[3:0] = time_q[3:0] + 4'd1;
    end else begin
      time_inc[3:0] = 4'd0;
      if (time_q[7:4] != 4'd9) begin
        time_inc[7:4] = time_q[7:4] + 4'd1;
      end else begin
        time_inc[7:4] = 4'd0;
        if (time_q[11:8] != 4'd9) begin
          time_inc[11:8] = time_q[11:8] + 4'd1;
        end else begin
          time_inc[11:8] = 4'd0;
          if (time_q[15:12] != 4'd5) begin
            time_inc[15:12] = time_q[15:12] + 4'd1;
          end else begin
            time_inc[15:12] = 4'd0;
            at_max          = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      time_q  <= '0;
      wrap    <= 1'b0;
    end else if (clear_p) begin
      presc_q <= '0;
      time_q  <= '0;
      wrap    <= 1'b0;
    end else begin
      wrap <= tick & at_max;
      if (tick) time_q <= time_inc;
      // PAUSED keeps the partial tick so resume finishes the interrupted hundredth.
      case (state_q)
        RUN:     presc_q <= tick ? '0 : presc_q + PW'(1);
        PAUSED:  presc_q <= presc_q;
        default: presc_q <= '0;
      endcase
    end
  end

`ifdef BCD_STOPWATCH_LAP_EN
  logic        lap_p, lap_hold_q;
  logic [15:0] snap_q;

  bcd_stopwatch_btn #(.DEB_CYCLES(DEB_CYCLES)) u_btn_lap (
    .clk(clk), .rst_n(rst_n), .btn(btn_lap), .press(lap_p)
  );

  // NOTE: the snapshot is a plain 16-bit register, so it is reset like any other flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lap_hold_q <= 1'b0;
      snap_q     <= '0;
    end else if (clear_p || state_d == IDLE) begin
      lap_hold_q <= 1'b0;
    end else if (lap_p && state_q == RUN) begin
      lap_hold_q <= ~lap_hold_q;
      if (!lap_hold_q) snap_q <= time_q;
    end
  end

  assign digits = lap_hold_q ? snap_q : time_q;
`else
  logic unused_lap;
  assign unused_lap = btn_lap;
  assign digits     = time_q;
`endif
endmodule
